// File: rtl/comp_thresh_readback_fsm.sv
// -----------------------------------------------------------------------------
// comp_thresh_readback_fsm
//
// Serial readback engine for the comparator-threshold DAC chain. It is the
// receive-side counterpart of the threshold load FSM. When START is raised,
// the engine gates WIDTH shift cycles out to the DAC chain. It captures the
// chain's serial output (SDO) into a parallel word, which software uses to
// verify the loaded thresholds. START is a level request: it is held high
// until RD_DONE is seen and then dropped.
//
// All registers update on the FALLING edge of CLK.
//
// Optional build macro: CTL_RDBK_TMR_EN
//   - Defined: state, count, shift register, SHFT_ENA, BUSY, RD_DONE and
//     RD_DATA are triplicated. Each replica computes its next value from the
//     majority-voted copies, so every replica reloads from the vote each cycle
//     (self-scrubbing). The outputs are voted. TMR_ERR latches any
//     disagreement between replicas.
//   - Undefined: a single copy is built and TMR_ERR is tied to 0.
//   Cycle behaviour is identical in both builds.
//
// Parameters
//   WIDTH      bits per readback word (2..32)
//   MSB_FIRST  1: the first captured bit lands in RD_DATA[WIDTH-1]
//              0: the first captured bit lands in RD_DATA[0]
//
// Ports
//   CLK       in   system clock (falling-edge active)
//   RST       in   asynchronous active-high reset
//   START     in   readback request (level)
//   SDO       in   serial data from the DAC chain, sampled while shifting
//   SHFT_ENA  out  high for exactly WIDTH cycles per readback
//   BUSY      out  high in Arm and Shift
//   RD_DONE   out  high in Done
//   RD_DATA   out  last completed readback word
//   TMR_ERR   out  sticky replica-mismatch flag (0 when TMR is not built)
// -----------------------------------------------------------------------------
module comp_thresh_readback_fsm #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SDO,
    output logic             SHFT_ENA,
    output logic             BUSY,
    output logic             RD_DONE,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             TMR_ERR
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARM   = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] ST_SHIFT = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef CTL_RDBK_TMR_EN
    localparam int NREP = 3;
`else
    localparam int NREP = 1;
`endif

    // Shift one serial bit into the capture register in the configured order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                   input logic b);
        if (MSB_FIRST) begin
            shift_in = {s[WIDTH-2:0], b};
        end else begin
            shift_in = {b, s[WIDTH-1:1]};
        end
    endfunction

    // Per-replica register values, gathered for voting.
    logic [1:0]       state_rep [NREP];
    logic [CW-1:0]    count_rep [NREP];
    logic [WIDTH-1:0] sreg_rep  [NREP];
    logic [WIDTH-1:0] data_rep  [NREP];
    logic             shft_rep  [NREP];
    logic             busy_rep  [NREP];
    logic             done_rep  [NREP];

    // Voted view of the state (this is the single copy when TMR is not built).
    logic [1:0]       v_state;
    logic [CW-1:0]    v_count;
    logic [WIDTH-1:0] v_sreg;
    logic [WIDTH-1:0] v_data;
    logic             v_shft;
    logic             v_busy;
    logic             v_done;

    for (genvar r = 0; r < NREP; r++) begin : g_rep
        (* keep = "true", preserve = "true" *) logic [1:0]       state_r;
        (* keep = "true", preserve = "true" *) logic [CW-1:0]    count_r;
        (* keep = "true", preserve = "true" *) logic [WIDTH-1:0] sreg_r;
        (* keep = "true", preserve = "true" *) logic [WIDTH-1:0] data_r;
        (* keep = "true", preserve = "true" *) logic             shft_r;
        (* keep = "true", preserve = "true" *) logic             busy_r;
        (* keep = "true", preserve = "true" *) logic             done_r;

        logic [1:0]       state_nx;
        logic [CW-1:0]    count_nx;
        logic [WIDTH-1:0] sreg_nx;
        logic [WIDTH-1:0] data_nx;

        // Next-state and datapath: computed from the voted values so that a
        // corrupted replica is rewritten on the following edge.
        always_comb begin
            state_nx = ST_IDLE;
            count_nx = v_count;
            sreg_nx  = v_sreg;
            data_nx  = v_data;
            case (v_state)
                ST_IDLE: begin
                    if (START) begin
                        state_nx = ST_ARM;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    state_nx = ST_SHIFT;
                    count_nx = {CW{1'b0}};
                end
                ST_SHIFT: begin
                    sreg_nx  = shift_in(v_sreg, SDO);
                    count_nx = v_count + CNT_ONE;
                    // The final capture and the word commit happen on the
                    // same edge, so a partial word never reaches RD_DATA.
                    if (v_count == CNT_LAST) begin
                        state_nx = ST_DONE;
                        data_nx  = shift_in(v_sreg, SDO);
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (START) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                // An unknown (X) state falls back to Idle.
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        // Replica registers. The outputs are decoded from the next state so
        // that they are registered and line up with the state.
        always_ff @(negedge CLK or posedge RST) begin
            if (RST) begin
                state_r <= ST_IDLE;
                count_r <= {CW{1'b0}};
                sreg_r  <= {WIDTH{1'b0}};
                data_r  <= {WIDTH{1'b0}};
                shft_r  <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                state_r <= state_nx;
                count_r <= count_nx;
                sreg_r  <= sreg_nx;
                data_r  <= data_nx;
                shft_r  <= (state_nx == ST_SHIFT);
                busy_r  <= (state_nx == ST_ARM) || (state_nx == ST_SHIFT);
                done_r  <= (state_nx == ST_DONE);
            end
        end

        assign state_rep[r] = state_r;
        assign count_rep[r] = count_r;
        assign sreg_rep[r]  = sreg_r;
        assign data_rep[r]  = data_r;
        assign shft_rep[r]  = shft_r;
        assign busy_rep[r]  = busy_r;
        assign done_rep[r]  = done_r;
    end

`ifdef CTL_RDBK_TMR_EN
    // Bitwise 2-of-3 majority.
    function automatic logic [31:0] maj3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // True when any of the three copies differ.
    function automatic logic diff3(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] c);
        diff3 = (a != b) || (a != c);
    endfunction

    assign v_state = 2'(maj3(32'(state_rep[0]), 32'(state_rep[1]), 32'(state_rep[2])));
    assign v_count = CW'(maj3(32'(count_rep[0]), 32'(count_rep[1]), 32'(count_rep[2])));
    assign v_sreg  = WIDTH'(maj3(32'(sreg_rep[0]), 32'(sreg_rep[1]), 32'(sreg_rep[2])));
    assign v_data  = WIDTH'(maj3(32'(data_rep[0]), 32'(data_rep[1]), 32'(data_rep[2])));
    assign v_shft  = (shft_rep[0] & shft_rep[1]) | (shft_rep[0] & shft_rep[2]) | (shft_rep[1] & shft_rep[2]);
    assign v_busy  = (busy_rep[0] & busy_rep[1]) | (busy_rep[0] & busy_rep[2]) | (busy_rep[1] & busy_rep[2]);
    assign v_done  = (done_rep[0] & done_rep[1]) | (done_rep[0] & done_rep[2]) | (done_rep[1] & done_rep[2]);

    logic rep_diff;
    logic tmr_err_r;

    assign rep_diff = diff3(32'(state_rep[0]), 32'(state_rep[1]), 32'(state_rep[2]))
                    | diff3(32'(count_rep[0]), 32'(count_rep[1]), 32'(count_rep[2]))
                    | diff3(32'(sreg_rep[0]),  32'(sreg_rep[1]),  32'(sreg_rep[2]))
                    | diff3(32'(data_rep[0]),  32'(data_rep[1]),  32'(data_rep[2]))
                    | diff3(32'(shft_rep[0]),  32'(shft_rep[1]),  32'(shft_rep[2]))
                    | diff3(32'(busy_rep[0]),  32'(busy_rep[1]),  32'(busy_rep[2]))
                    | diff3(32'(done_rep[0]),  32'(done_rep[1]),  32'(done_rep[2]));

    // Sticky mismatch flag: set on any disagreement, cleared only by reset.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            tmr_err_r <= 1'b0;
        end else if (rep_diff) begin
            tmr_err_r <= 1'b1;
        end else begin
            tmr_err_r <= tmr_err_r;
        end
    end

    assign TMR_ERR = tmr_err_r;
`else
    assign v_state = state_rep[0];
    assign v_count = count_rep[0];
    assign v_sreg  = sreg_rep[0];
    assign v_data  = data_rep[0];
    assign v_shft  = shft_rep[0];
    assign v_busy  = busy_rep[0];
    assign v_done  = done_rep[0];
    assign TMR_ERR = 1'b0;
`endif

    assign SHFT_ENA = v_shft;
    assign BUSY     = v_busy;
    assign RD_DONE  = v_done;
    assign RD_DATA  = v_data;

endmodule

// File: tb/tb_comp_thresh_readback_fsm.sv
// -----------------------------------------------------------------------------
// tb_comp_thresh_readback_fsm
//
// Bench for comp_thresh_readback_fsm with WIDTH=16. Two instances share the
// same stimulus: one is built MSB-first and the other LSB-first. Expected
// words are pushed to per-instance queues when a transfer is started. They
// are popped and compared when RD_DONE is seen. Inputs are driven, and
// outputs sampled, 1 time unit after each falling (active) edge.
// -----------------------------------------------------------------------------
module tb_comp_thresh_readback_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sdo;
    logic        shft_m, busy_m, done_m, err_m;
    logic        shft_l, busy_l, done_l, err_l;
    logic [15:0] data_m, data_l;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q_m [$];
    logic [15:0] q_l [$];

    comp_thresh_readback_fsm #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .CLK(clk), .RST(rst), .START(start), .SDO(sdo),
        .SHFT_ENA(shft_m), .BUSY(busy_m), .RD_DONE(done_m),
        .RD_DATA(data_m), .TMR_ERR(err_m)
    );

    comp_thresh_readback_fsm #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .CLK(clk), .RST(rst), .START(start), .SDO(sdo),
        .SHFT_ENA(shft_l), .BUSY(busy_l), .RD_DONE(done_l),
        .RD_DATA(data_l), .TMR_ERR(err_l)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [15:0] bitrev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    // Runs one readback from Idle. Edge j=0 is the first edge that sees
    // START=1. Stops once RD_DONE is seen, or after 40 edges.
    task automatic do_xfer(input logic [15:0] word, input int drop_edge, input int inj_edge,
                           output int shft_cnt, output int shft_first, output int shft_last,
                           output int done_edge, output int busy0,
                           output logic [15:0] got_m, output logic [15:0] got_l,
                           output logic [15:0] pre_m, output logic tmr_after,
                           output logic [1:0] rep_after);
        shft_cnt = 0; shft_first = -1; shft_last = -1; done_edge = -1; busy0 = 0;
        got_m = 16'h0000; got_l = 16'h0000; pre_m = 16'h0000;
        tmr_after = 1'b0; rep_after = 2'b00;
        start = 1'b1;
        for (int j = 0; j < 40 && done_edge < 0; j++) begin
            if (j >= 2 && j <= 17) sdo = word[17-j];
            else sdo = 1'b0;
            if (j == drop_edge) start = 1'b0;
            @(negedge clk);
            #1;
            if (j == 0) busy0 = busy_m ? 1 : 0;
            if (j == 16) pre_m = data_m;
            if (shft_m || shft_l) begin
                shft_cnt++;
                if (shft_first < 0) shft_first = j;
                shft_last = j;
            end
            if (done_m) begin
                done_edge = j;
                got_m = data_m;
                got_l = data_l;
            end
`ifdef CTL_RDBK_TMR_EN
            if (j == inj_edge) dut_m.g_rep[2].state_r = 2'b00;
            if (j == inj_edge + 1) begin
                tmr_after = err_m;
                rep_after = dut_m.g_rep[2].state_r;
            end
`else
            if (j == inj_edge + 1) tmr_after = err_m;
`endif
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sdo = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if ({shft_m, busy_m, done_m, err_m} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {shft_m, busy_m, done_m, err_m}); end
        n_cmp++; if (data_m !== 16'h0000) begin n_err++; $display("FAIL reset_data_m got %h want 0000", data_m); end
        n_cmp++; if (data_l !== 16'h0000) begin n_err++; $display("FAIL reset_data_l got %h want 0000", data_l); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if ({busy_m, done_m} !== 2'b00) begin n_err++; $display("FAIL idle_no_start got %b want 00", {busy_m, done_m}); end
    endtask

    task automatic test_nominal;
        int sc, sf, sl, de, b0;
        logic [15:0] gm, gl, pm;
        logic ta;
        logic [1:0] ra;
        int dcnt;
        logic [15:0] em, el;
        q_m.push_back(16'hA5C3);
        q_l.push_back(bitrev16(16'hA5C3));
        do_xfer(16'hA5C3, -1, -10, sc, sf, sl, de, b0, gm, gl, pm, ta, ra);
        n_cmp++; if (b0 !== 1) begin n_err++; $display("FAIL nom_busy_arm got %0d want 1", b0); end
        n_cmp++; if (sc !== 16 || sf !== 1 || sl !== 16) begin n_err++; $display("FAIL nom_shft got cnt=%0d first=%0d last=%0d want 16/1/16", sc, sf, sl); end
        n_cmp++; if (de !== 17) begin n_err++; $display("FAIL nom_done_edge got %0d want 17", de); end
        if (q_m.size() == 0 || q_l.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL nom_queue got empty want 1 entry");
        end else begin
            em = q_m.pop_front(); el = q_l.pop_front();
            n_cmp++; if (gm !== em) begin n_err++; $display("FAIL nom_data_m got %h want %h", gm, em); end
            n_cmp++; if (gl !== el) begin n_err++; $display("FAIL nom_data_l got %h want %h", gl, el); end
        end
        // START is still high: Done must persist for as long as START is held.
        dcnt = 1;
        repeat (4) begin
            @(negedge clk); #1;
            if (done_m && !busy_m && !shft_m) dcnt++;
        end
        n_cmp++; if (dcnt !== 5) begin n_err++; $display("FAIL nom_done_hold got %0d want 5", dcnt); end
        start = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({done_m, busy_m, shft_m} !== 3'b000) begin n_err++; $display("FAIL nom_back_idle got %b want 000", {done_m, busy_m, shft_m}); end
        n_cmp++; if (data_m !== 16'hA5C3) begin n_err++; $display("FAIL nom_data_hold got %h want a5c3", data_m); end
        n_cmp++; if (err_m !== 1'b0) begin n_err++; $display("FAIL nom_tmr_err got %b want 0", err_m); end
        @(negedge clk); #1;
    endtask

    task automatic test_lsb_first;
        int sc, sf, sl, de, b0;
        logic [15:0] gm, gl, pm, el;
        logic ta;
        logic [1:0] ra;
        q_l.push_back(bitrev16(16'h1234));
        do_xfer(16'h1234, -1, -10, sc, sf, sl, de, b0, gm, gl, pm, ta, ra);
        start = 1'b0;
        if (q_l.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL lsb_queue got empty want 1 entry");
        end else begin
            el = q_l.pop_front();
            n_cmp++; if (gl !== el) begin n_err++; $display("FAIL lsb_data got %h want %h", gl, el); end
        end
        n_cmp++; if (gm !== 16'h1234) begin n_err++; $display("FAIL lsb_ref_m got %h want 1234", gm); end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_start_drop;
        int sc, sf, sl, de, b0;
        logic [15:0] gm, gl, pm;
        logic ta;
        logic [1:0] ra;
        q_m.push_back(16'hFFFF);
        q_l.push_back(16'hFFFF);
        do_xfer(16'hFFFF, 4, -10, sc, sf, sl, de, b0, gm, gl, pm, ta, ra);
        n_cmp++; if (sc !== 16 || de !== 17) begin n_err++; $display("FAIL drop_timing got cnt=%0d done=%0d want 16/17", sc, de); end
        if (q_m.size() == 0 || q_l.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL drop_queue got empty want 1 entry");
        end else begin
            n_cmp++; if (gm !== q_m.pop_front() || gl !== q_l.pop_front()) begin n_err++; $display("FAIL drop_data got %h/%h want ffff/ffff", gm, gl); end
        end
        @(negedge clk); #1;
        n_cmp++; if ({done_m, busy_m, shft_m} !== 3'b000) begin n_err++; $display("FAIL drop_pulse_idle got %b want 000", {done_m, busy_m, shft_m}); end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int sc, sf, sl, de, b0;
        logic [15:0] gm, gl, pm;
        logic ta;
        logic [1:0] ra;
        do_xfer(16'h5A5A, -1, -10, sc, sf, sl, de, b0, gm, gl, pm, ta, ra);
        n_cmp++; if (gm !== 16'h5A5A) begin n_err++; $display("FAIL b2b_first got %h want 5a5a", gm); end
        start = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({done_m, shft_m} !== 2'b00) begin n_err++; $display("FAIL b2b_gap got %b want 00", {done_m, shft_m}); end
        q_m.push_back(16'h0001);
        do_xfer(16'h0001, -1, -10, sc, sf, sl, de, b0, gm, gl, pm, ta, ra);
        n_cmp++; if (pm !== 16'h5A5A) begin n_err++; $display("FAIL b2b_hold got %h want 5a5a", pm); end
        n_cmp++; if (sc !== 16 || sf !== 1 || sl !== 16 || de !== 17) begin n_err++; $display("FAIL b2b_shft got cnt=%0d first=%0d last=%0d done=%0d want 16/1/16/17", sc, sf, sl, de); end
        if (q_m.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL b2b_queue got empty want 1 entry");
        end else begin
            n_cmp++; if (gm !== q_m.pop_front()) begin n_err++; $display("FAIL b2b_second got %h want 0001", gm); end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        start = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            sdo = j[0];
            @(negedge clk); #1;
        end
        n_cmp++; if (shft_m !== 1'b1) begin n_err++; $display("FAIL abort_mid_shift got %b want 1", shft_m); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({shft_m, busy_m, done_m, err_m} !== 4'b0000) begin n_err++; $display("FAIL abort_flags got %b want 0000", {shft_m, busy_m, done_m, err_m}); end
        n_cmp++; if (data_m !== 16'h0000 || data_l !== 16'h0000) begin n_err++; $display("FAIL abort_data got %h/%h want 0000/0000", data_m, data_l); end
        start = 1'b0;
        #2 rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #1;
            n_cmp++; if ({done_m, busy_m, shft_m} !== 3'b000) begin n_err++; $display("FAIL abort_idle%0d got %b want 000", j, {done_m, busy_m, shft_m}); end
        end
    endtask

`ifdef CTL_RDBK_TMR_EN
    task automatic test_tmr;
        int sc, sf, sl, de, b0;
        logic [15:0] gm, gl, pm;
        logic ta;
        logic [1:0] ra;
        do_xfer(16'h3C96, -1, 6, sc, sf, sl, de, b0, gm, gl, pm, ta, ra);
        n_cmp++; if (sc !== 16 || de !== 17) begin n_err++; $display("FAIL tmr_timing got cnt=%0d done=%0d want 16/17", sc, de); end
        n_cmp++; if (gm !== 16'h3C96) begin n_err++; $display("FAIL tmr_data got %h want 3c96", gm); end
        n_cmp++; if (ta !== 1'b1) begin n_err++; $display("FAIL tmr_err_set got %b want 1", ta); end
        n_cmp++; if (ra !== 2'b11) begin n_err++; $display("FAIL tmr_resync got %b want 11", ra); end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (err_m !== 1'b1) begin n_err++; $display("FAIL tmr_sticky got %b want 1", err_m); end
        rst = 1'b1;
        #1;
        n_cmp++; if (err_m !== 1'b0) begin n_err++; $display("FAIL tmr_rst_clear got %b want 0", err_m); end
        #2 rst = 1'b0;
        @(negedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; sdo = 1'b0;
        test_reset();
        test_nominal();
        test_lsb_first();
        test_start_drop();
        test_back_to_back();
        test_reset_abort();
`ifdef CTL_RDBK_TMR_EN
        test_tmr();
`endif
        n_cmp++; if (err_l !== 1'b0 && err_m !== 1'b0) begin n_err++; $display("FAIL final_tmr_err got %b/%b want 0/0", err_m, err_l); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
